// File: rtl/io_seq_checker.sv
// io_seq_checker: watches obs_i against a programmable table of expected
// values in wait or strict mode, with optional timeout (SEQ_CHECK_TIMEOUT_EN).
// Ports: wb_clk_i/wb_rst_i clock + sync reset; cfg_* table write and check
// config; start arms a check; ready_i gates ARM->RUN; obs_i observed bus;
// busy/pass/fail/fail_idx/fail_tmo/match_cnt report status.
module io_seq_checker #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 16,
  parameter int TMO_W  = 24
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       cfg_strict,
  input  logic [TMO_W-1:0]           cfg_tmo,
  input  logic                       start,
  input  logic                       ready_i,
  input  logic [DATA_W-1:0]          obs_i,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic                       fail_tmo,
  output logic [$clog2(DEPTH):0]     match_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_PASS, S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] tbl_q [DEPTH];
  logic [DATA_W-1:0] obs_q;
  logic [DATA_W-1:0] obs_p_q, obs_p_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic              strict_q, strict_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic              ftmo_q, ftmo_d;

  logic [LW-1:0]     len_clamp;
  logic              hit, chg, match, mism;

`ifdef SEQ_CHECK_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0]  tmo_lim_q, tmo_lim_d;
`else
  logic              unused_tmo;
  assign unused_tmo = ^cfg_tmo;
`endif

  // Table is writable only while no check is in progress.
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && !busy) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
    obs_q <= obs_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      obs_p_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      strict_q  <= 1'b0;
      fidx_q    <= '0;
      ftmo_q    <= 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_lim_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      obs_p_q   <= obs_p_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      strict_q  <= strict_d;
      fidx_q    <= fidx_d;
      ftmo_q    <= ftmo_d;
`ifdef SEQ_CHECK_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_lim_q <= tmo_lim_d;
`endif
    end
  end

  assign len_clamp = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
  assign hit   = (obs_q == tbl_q[idx_q]);
  assign chg   = (obs_q != obs_p_q);
  assign match = strict_q ? (chg && hit) : hit;
  assign mism  = strict_q && chg && !hit;

  always_comb begin
    state_d   = state_q;
    obs_p_d   = obs_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    strict_d  = strict_q;
    fidx_d    = fidx_q;
    ftmo_d    = ftmo_q;
`ifdef SEQ_CHECK_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_lim_d = tmo_lim_q;
`endif
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          idx_d    = '0;
          cnt_d    = '0;
          fidx_d   = '0;
          ftmo_d   = 1'b0;
          len_d    = len_clamp;
          strict_d = cfg_strict;
`ifdef SEQ_CHECK_TIMEOUT_EN
          tmo_cnt_d = '0;
          tmo_lim_d = cfg_tmo;
`endif
          state_d = (len_clamp == '0) ? S_PASS : S_ARM;
        end
      end
      S_ARM: begin
        if (ready_i) begin
          state_d = S_RUN;
          // Level present at RUN entry must not look like a change.
          obs_p_d = obs_i;
        end
      end
      S_RUN: begin
        if (match) begin
          idx_d = idx_q + AW'(1);
          cnt_d = cnt_q + LW'(1);
`ifdef SEQ_CHECK_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (cnt_q + LW'(1) == len_q) begin
            state_d = S_PASS;
          end
        end else if (mism) begin
          state_d = S_FAIL;
          fidx_d  = idx_q;
          ftmo_d  = 1'b0;
        end else begin
`ifdef SEQ_CHECK_TIMEOUT_EN
          if (tmo_lim_q != '0) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_d == tmo_lim_q) begin
              state_d = S_FAIL;
              fidx_d  = idx_q;
              ftmo_d  = 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_ARM) || (state_q == S_RUN);
    pass      = (state_q == S_PASS);
    fail      = (state_q == S_FAIL);
    fail_idx  = fidx_q;
    fail_tmo  = ftmo_q;
    match_cnt = cnt_q;
  end

endmodule

// File: doc/io_seq_checker.md
# io_seq_checker

Synthesizable on-chip sequence checker for the user project. It watches a DATA_W-bit observation bus, normally the user outputs driven onto mprj_io[35:8]. It compares the bus against a programmable table of expected values and reports pass or fail with the failing index. It moves the "wait for value N, then N+1, ..." checking that the dv benches do today into a reusable RTL block, generalised in width, depth and match mode, and with a timeout.

## Interface
Parameters:
- DATA_W, 28, width of the observed bus and of each expected entry.
- DEPTH, 16, number of expected-table entries (power of two, ≥2).
- TMO_W, 24, width of the timeout counter.

Ports:
- wb_clk_i  in  1  single clock; everything is on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for one expected-table entry.
- cfg_addr  in  $clog2(DEPTH)  table index to write.
- cfg_data  in  DATA_W  expected value to write.
- cfg_len  in  $clog2(DEPTH)+1  number of entries to check; values above DEPTH clamp to DEPTH.
- cfg_strict  in  1  mode select: 0 = wait mode, 1 = strict mode.
- cfg_tmo  in  TMO_W  timeout limit in cycles; 0 disables the timeout.
- start  in  1  one-cycle pulse that arms a check.
- ready_i  in  1  gate from the design under observation (the mprj_ready equivalent).
- obs_i  in  DATA_W  observed bus.
- busy  out  1  high in ARM and RUN.
- pass  out  1  sticky pass flag.
- fail  out  1  sticky fail flag.
- fail_idx  out  $clog2(DEPTH)  table index being waited on when fail set.
- fail_tmo  out  1  1 = fail caused by timeout, 0 = fail caused by strict mismatch.
- match_cnt  out  $clog2(DEPTH)+1  number of entries matched so far.

## Operation
- Expected table: DEPTH×DATA_W registers.
  - Written by cfg_we only while busy=0.
  - cfg_we while busy=1 is ignored.
- Input register: obs_q <= obs_i on every edge. All comparisons use obs_q. obs_p holds the previous obs_q.
- States are IDLE, ARM, RUN, PASS, FAIL. Reset goes to IDLE.
- IDLE/PASS/FAIL with start=1:
  - Go to ARM.
  - Clear pass, fail, fail_tmo, fail_idx, match_cnt, idx and the timeout counter.
  - Latch the clamped cfg_len, cfg_strict and cfg_tmo.
  - If the latched length is 0, go to PASS instead of ARM.
- ARM: wait for ready_i=1, then go to RUN. The timeout counter does not run in ARM.
- RUN, wait mode:
  - If obs_q == table[idx], count a match.
  - All other values are ignored.
  - A level that already equals the entry when RUN is entered matches at once.
  - Equal adjacent entries match on consecutive cycles.
- RUN, strict mode:
  - Only a change (obs_q != obs_p) is evaluated.
  - If the changed value equals table[idx], count a match. Otherwise go to FAIL with fail_tmo=0.
  - No change means no match, so equal adjacent entries can never both match.
  - obs_p is loaded with obs_q on RUN entry, so the level present at entry is not a change.
- On a match:
  - Increment idx and match_cnt, and clear the timeout counter.
  - When match_cnt reaches the latched length, go to PASS.
- Timeout: in RUN with cfg_tmo≠0, the counter increments each cycle without a match. At counter == cfg_tmo, go to FAIL with fail_tmo=1.
- Priority within one RUN cycle: match > strict mismatch > timeout.
- start while busy is ignored. ready_i falling during RUN is ignored.

## Timing
- Reset values: busy=0, pass=0, fail=0, fail_tmo=0, fail_idx=0, match_cnt=0, state IDLE. The table contents are not reset.
- Latency: obs_i captured at edge E is compared in the following cycle. match_cnt, pass and fail update at edge E+1.
- start at edge S gives busy=1 after S. With ready_i already high, RUN begins after S+1.
- Timeout fires on the edge where cfg_tmo cycles have elapsed without a match. With cfg_tmo=1, it fires on the first non-matching RUN cycle.
- pass and fail hold until the next accepted start or reset. Both are never high together.
- wb_rst_i mid-run: at the next edge, go to IDLE and clear all flags and counters. The latched config is discarded.

## Configuration
- SEQ_CHECK_TIMEOUT_EN:
  - When defined: the timeout counter, cfg_tmo and fail_tmo behave as specified above.
  - When undefined: there is no counter, cfg_tmo is ignored and fail_tmo is tied to 0. Failure is possible only through a strict mismatch, and wait mode can only pass or stay busy.

## Test plan
- Wait mode: table {5,10,15,20,25,30}, len=6, ready_i=1, obs_i steps 0,5,7,10,15,3,20,25,30 → pass=1 two edges after 30 is presented, match_cnt=6, fail=0.
- Strict mode: same table, obs_i sequence 5,10,12 → fail=1, fail_tmo=0, fail_idx=2, match_cnt=2.
- Timeout: wait mode, cfg_tmo=100, table {64}, obs_i held at 0 → fail=1, fail_tmo=1 at exactly 100 RUN cycles. With the macro undefined → busy stays 1 and fail=0.
- Gating and config: start with ready_i=0 for 50 cycles → no matches while in ARM. A cfg_we issued while busy must not alter the table (read back via a later check). len=0 → pass one edge after start.
- Clamp and wrap: DEPTH=16, cfg_len=20, a 16-entry ramp 0..15 → pass with match_cnt=16.
- Reset mid-run: wb_rst_i asserted after 3 matches → all outputs reach their reset values at the next edge. A new start then re-checks from idx 0.
